rx_serial_8o1: RTL and testbench

Asynchronous serial receiver for the 8O1 frame produced by the team's serial transmitter. The frame is idle-high, then 1 start bit (0), then 8 data bits LSB first, then an odd-parity bit, then 1 stop bit (1).
The block sits directly downstream of the transmitter (loopback or a separate board). It oversamples the line with the system clock, samples each bit at its centre and delivers the received byte with error flags and a hold/clear handshake.
It is structured as a control unit plus a datapath, following the team's uc/fd split.

---
 rtl/rx_serial_8o1_pkg.sv | 17 +
 rtl/contador_m.sv | 20 ++
 rtl/rx_serial_8o1_fd.sv | 85 ++++++++
 rtl/rx_serial_8o1_uc.sv | 89 ++++++++
 rtl/rx_serial_8o1.sv | 71 +++++++
 tb/tb_rx_serial_8o1.sv | 177 +++++++++++++++++
 6 files changed

// File: rtl/rx_serial_8o1_pkg.sv
// Shared definitions for the 8O1 serial receiver: FSM state codes seen on db_estado.
package rx_serial_8o1_pkg;

    typedef enum logic [3:0] {
        INICIAL      = 4'd0,
        REPOUSO      = 4'd1,
        START        = 4'd2,
        DADOS        = 4'd3,
        PARIDADE     = 4'd4,
        STOP         = 4'd5,
        FINAL        = 4'd6,
        ESPERA_LINHA = 4'd7
    } estado_t;

    localparam int BITS_DADO = 8;

endpackage

// File: rtl/contador_m.sv
// Modulo-M up counter with synchronous clear and count enable.
module contador_m #(
    parameter int M = 16,
    parameter int N = $clog2(M)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera,
    input  logic         conta,
    output logic [N-1:0] Q
);

    always_ff @(posedge clock) begin
        if (reset || zera)
            Q <= '0;
        else if (conta)
            Q <= (Q == N'(M-1)) ? '0 : Q + 1'b1;
    end

endmodule

// File: rtl/rx_serial_8o1_fd.sv
// Receiver datapath: line synchroniser, bit timing counters, shift register, result registers.
module rx_serial_8o1_fd
    import rx_serial_8o1_pkg::*;
#(
    parameter int M = 434
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_dado_serial,
    input  logic                 i_limpa,
    input  logic                 i_zera_ciclo,
    input  logic                 i_conta_ciclo,
    input  logic                 i_zera_bit,
    input  logic                 i_conta_bit,
    input  logic                 i_desloca,
    input  logic                 i_carrega_par,
    input  logic                 i_carrega_stop,
    input  logic                 i_registra,
    output logic                 o_rx,
    output logic                 o_meio,
    output logic                 o_fim_ciclo,
    output logic                 o_fim_bit,
    output logic                 o_stop_bit,
    output logic [BITS_DADO-1:0] o_dados_ascii,
    output logic                 o_tem_dado,
    output logic                 o_erro_paridade,
    output logic                 o_erro_stop,
    output logic                 o_overrun
);

    localparam int CW = $clog2(M);

    logic [1:0]           r_sync;
    logic [BITS_DADO-1:0] r_shift;
    logic                 r_par;
    logic                 r_stop;
    logic [CW-1:0]        w_ciclo;
    logic [3:0]           w_bit;

    contador_m #(.M(M), .N(CW)) u_ciclo (
        .clock (clock), .reset (reset),
        .zera  (i_zera_ciclo), .conta (i_conta_ciclo), .Q (w_ciclo)
    );

    contador_m #(.M(9), .N(4)) u_bit (
        .clock (clock), .reset (reset),
        .zera  (i_zera_bit), .conta (i_conta_bit), .Q (w_bit)
    );

    assign o_rx        = r_sync[1];
    assign o_meio      = (w_ciclo == CW'(M/2 - 1));
    assign o_fim_ciclo = (w_ciclo == CW'(M - 1));
    assign o_fim_bit   = (w_bit == 4'd8);
    assign o_stop_bit  = r_stop;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync          <= 2'b11;
            r_shift         <= '0;
            r_par           <= 1'b0;
            r_stop          <= 1'b0;
            o_dados_ascii   <= '0;
            o_tem_dado      <= 1'b0;
            o_erro_paridade <= 1'b0;
            o_erro_stop     <= 1'b0;
            o_overrun       <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_dado_serial};
            // LSB arrives first, so shifting right leaves it at bit 0
            if (i_desloca)      r_shift <= {o_rx, r_shift[BITS_DADO-1:1]};
            if (i_carrega_par)  r_par   <= o_rx;
            if (i_carrega_stop) r_stop  <= o_rx;
            if (i_registra) begin
                o_dados_ascii   <= r_shift;
                o_erro_paridade <= ~(^{r_shift, r_par});
                o_erro_stop     <= ~r_stop;
                o_overrun       <= o_overrun | (o_tem_dado & ~i_limpa);
                o_tem_dado      <= 1'b1;
            end else if (i_limpa) begin
                o_tem_dado <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rx_serial_8o1_uc.sv
// Receiver control unit: frame sequencing FSM, drives the datapath strobes.
module rx_serial_8o1_uc
    import rx_serial_8o1_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       i_rx,
    input  logic       i_meio,
    input  logic       i_fim_ciclo,
    input  logic       i_fim_bit,
    input  logic       i_stop_bit,
    output logic       o_zera_ciclo,
    output logic       o_conta_ciclo,
    output logic       o_zera_bit,
    output logic       o_conta_bit,
    output logic       o_desloca,
    output logic       o_carrega_par,
    output logic       o_carrega_stop,
    output logic       o_registra,
    output logic [3:0] o_estado
);

    estado_t r_estado, w_prox;

    always_ff @(posedge clock) begin
        if (reset) r_estado <= INICIAL;
        else       r_estado <= w_prox;
    end

    always_comb begin
        w_prox         = r_estado;
        o_zera_ciclo   = 1'b0;
        o_conta_ciclo  = 1'b0;
        o_zera_bit     = 1'b0;
        o_conta_bit    = 1'b0;
        o_desloca      = 1'b0;
        o_carrega_par  = 1'b0;
        o_carrega_stop = 1'b0;
        o_registra     = 1'b0;
        case (r_estado)
            INICIAL: w_prox = REPOUSO;
            REPOUSO: begin
                o_zera_ciclo = 1'b1;
                if (!i_rx) w_prox = START;
            end
            START: begin
                o_conta_ciclo = 1'b1;
                o_zera_bit    = 1'b1;
                if (i_meio) begin
                    // restart the cycle count here so later samples land mid-bit
                    o_zera_ciclo = 1'b1;
                    w_prox       = i_rx ? REPOUSO : DADOS;
                end
            end
            DADOS: begin
                o_conta_ciclo = 1'b1;
                if (i_fim_bit)
                    w_prox = PARIDADE;
                else if (i_fim_ciclo) begin
                    o_desloca   = 1'b1;
                    o_conta_bit = 1'b1;
                end
            end
            PARIDADE: begin
                o_conta_ciclo = 1'b1;
                if (i_fim_ciclo) begin
                    o_carrega_par = 1'b1;
                    w_prox        = STOP;
                end
            end
            STOP: begin
                o_conta_ciclo = 1'b1;
                if (i_fim_ciclo) begin
                    o_carrega_stop = 1'b1;
                    w_prox         = FINAL;
                end
            end
            FINAL: begin
                o_registra = 1'b1;
                w_prox     = i_stop_bit ? REPOUSO : ESPERA_LINHA;
            end
            ESPERA_LINHA: if (i_rx) w_prox = REPOUSO;
            default: w_prox = INICIAL;
        endcase
    end

    assign o_estado = r_estado;

endmodule

// File: rtl/rx_serial_8o1.sv
// 8O1 asynchronous serial receiver: control unit plus datapath.
module rx_serial_8o1
    import rx_serial_8o1_pkg::*;
#(
    parameter int M = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dado_serial,
    input  logic       limpa,
    output logic [7:0] dados_ascii,
    output logic       pronto,
    output logic       tem_dado,
    output logic       erro_paridade,
    output logic       erro_stop,
    output logic       overrun,
    output logic [3:0] db_estado
);

    logic w_rx, w_meio, w_fim_ciclo, w_fim_bit, w_stop_bit;
    logic w_zera_ciclo, w_conta_ciclo, w_zera_bit, w_conta_bit;
    logic w_desloca, w_carrega_par, w_carrega_stop, w_registra;

    rx_serial_8o1_uc u_uc (
        .clock          (clock),
        .reset          (reset),
        .i_rx           (w_rx),
        .i_meio         (w_meio),
        .i_fim_ciclo    (w_fim_ciclo),
        .i_fim_bit      (w_fim_bit),
        .i_stop_bit     (w_stop_bit),
        .o_zera_ciclo   (w_zera_ciclo),
        .o_conta_ciclo  (w_conta_ciclo),
        .o_zera_bit     (w_zera_bit),
        .o_conta_bit    (w_conta_bit),
        .o_desloca      (w_desloca),
        .o_carrega_par  (w_carrega_par),
        .o_carrega_stop (w_carrega_stop),
        .o_registra     (w_registra),
        .o_estado       (db_estado)
    );

    rx_serial_8o1_fd #(.M(M)) u_fd (
        .clock           (clock),
        .reset           (reset),
        .i_dado_serial   (dado_serial),
        .i_limpa         (limpa),
        .i_zera_ciclo    (w_zera_ciclo),
        .i_conta_ciclo   (w_conta_ciclo),
        .i_zera_bit      (w_zera_bit),
        .i_conta_bit     (w_conta_bit),
        .i_desloca       (w_desloca),
        .i_carrega_par   (w_carrega_par),
        .i_carrega_stop  (w_carrega_stop),
        .i_registra      (w_registra),
        .o_rx            (w_rx),
        .o_meio          (w_meio),
        .o_fim_ciclo     (w_fim_ciclo),
        .o_fim_bit       (w_fim_bit),
        .o_stop_bit      (w_stop_bit),
        .o_dados_ascii   (dados_ascii),
        .o_tem_dado      (tem_dado),
        .o_erro_paridade (erro_paridade),
        .o_erro_stop     (erro_stop),
        .o_overrun       (overrun)
    );

    // pronto is the FINAL cycle itself; the result registers update at its closing edge
    assign pronto = w_registra;

endmodule

// File: tb/tb_rx_serial_8o1.sv
// Directed bench for rx_serial_8o1 at M=16: clean, bad-parity, framing, glitch, overrun, reset frames.
module tb_rx_serial_8o1;
    import rx_serial_8o1_pkg::*;

    localparam int M = 16;
    localparam int FR = 11 * M;
    localparam int PRONTO_STEP = M/2 + 10*M + 2;   // step index at which pronto is sampled

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       dado_serial = 1'b1;
    logic       limpa = 1'b0;
    logic [7:0] dados_ascii;
    logic       pronto, tem_dado, erro_paridade, erro_stop, overrun;
    logic [3:0] db_estado;

    int n_checks = 0;
    int n_fail = 0;

    rx_serial_8o1 #(.M(M)) dut (
        .clock (clock), .reset (reset), .dado_serial (dado_serial), .limpa (limpa),
        .dados_ascii (dados_ascii), .pronto (pronto), .tem_dado (tem_dado),
        .erro_paridade (erro_paridade), .erro_stop (erro_stop), .overrun (overrun),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    // Drives one frame (start, 8 data LSB first, parity, stop) then `tail` cycles at tail_lvl.
    // limpa is raised at step limpa_at; reset at step rst_at aborts the frame.
    task automatic run_frame(input logic [7:0] d, input logic par, input logic stp,
                             input int limpa_at, input int rst_at, input int tail,
                             input logic tail_lvl, output int pcount, output int pfirst);
        logic [10:0] fr;
        fr = {stp, par, d, 1'b0};
        pcount = 0;
        pfirst = -1;
        for (int n = 0; n < FR + tail; n++) begin
            dado_serial = (n < FR) ? fr[n / M] : tail_lvl;
            limpa = (n == limpa_at);
            reset = (n == rst_at);
            @(posedge clock); #1;
            if (pronto) begin
                pcount++;
                if (pfirst < 0) pfirst = n;
            end
            if (n == rst_at) begin
                reset = 1'b0;
                dado_serial = 1'b1;
                limpa = 1'b0;
                return;
            end
        end
        limpa = 1'b0;
    endtask

    task automatic test_reset();
        dado_serial = 1'b1;
        limpa = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        n_checks++; if (db_estado !== INICIAL) begin n_fail++; $display("FAIL reset_estado got %0d want %0d", db_estado, INICIAL); end
        n_checks++; if ({dados_ascii, pronto, tem_dado, erro_paridade, erro_stop, overrun} !== 13'd0) begin
            n_fail++; $display("FAIL reset_outputs got %h/%b%b%b%b%b want 0", dados_ascii, pronto, tem_dado, erro_paridade, erro_stop, overrun); end
        reset = 1'b0;
        @(posedge clock); #1;
        n_checks++; if (db_estado !== REPOUSO) begin n_fail++; $display("FAIL reset_to_repouso got %0d want %0d", db_estado, REPOUSO); end
    endtask

    task automatic test_clean_frame();
        int pc, pf;
        run_frame(8'h41, 1'b1, 1'b1, -1, -1, 4, 1'b1, pc, pf);
        n_checks++; if (pc !== 1) begin n_fail++; $display("FAIL clean_pronto_count got %0d want 1", pc); end
        n_checks++; if (pf !== PRONTO_STEP) begin n_fail++; $display("FAIL clean_pronto_time got %0d want %0d", pf, PRONTO_STEP); end
        n_checks++; if (dados_ascii !== 8'h41) begin n_fail++; $display("FAIL clean_data got %h want 41", dados_ascii); end
        n_checks++; if ({tem_dado, erro_paridade, erro_stop, overrun} !== 4'b1000) begin
            n_fail++; $display("FAIL clean_flags got %b want 1000", {tem_dado, erro_paridade, erro_stop, overrun}); end
        n_checks++; if (db_estado !== REPOUSO) begin n_fail++; $display("FAIL clean_estado got %0d want %0d", db_estado, REPOUSO); end
    endtask

    task automatic test_limpa();
        limpa = 1'b1;
        @(posedge clock); #1;
        limpa = 1'b0;
        n_checks++; if (tem_dado !== 1'b0) begin n_fail++; $display("FAIL limpa_clears got %b want 0", tem_dado); end
        n_checks++; if (dados_ascii !== 8'h41) begin n_fail++; $display("FAIL limpa_holds_data got %h want 41", dados_ascii); end
    endtask

    task automatic test_parity_error();
        int pc, pf;
        run_frame(8'h41, 1'b0, 1'b1, -1, -1, 4, 1'b1, pc, pf);
        n_checks++; if (pc !== 1) begin n_fail++; $display("FAIL par_pronto_count got %0d want 1", pc); end
        n_checks++; if (dados_ascii !== 8'h41) begin n_fail++; $display("FAIL par_data got %h want 41", dados_ascii); end
        n_checks++; if ({erro_paridade, erro_stop, overrun} !== 3'b100) begin
            n_fail++; $display("FAIL par_flags got %b want 100", {erro_paridade, erro_stop, overrun}); end
    endtask

    task automatic test_stop_error();
        int pc, pf;
        run_frame(8'h55, 1'b1, 1'b0, 0, -1, 3*M, 1'b0, pc, pf);
        n_checks++; if (pc !== 1) begin n_fail++; $display("FAIL stop_pronto_count got %0d want 1", pc); end
        n_checks++; if ({erro_paridade, erro_stop} !== 2'b01) begin
            n_fail++; $display("FAIL stop_flags got %b want 01", {erro_paridade, erro_stop}); end
        n_checks++; if (db_estado !== ESPERA_LINHA) begin n_fail++; $display("FAIL stop_espera got %0d want %0d", db_estado, ESPERA_LINHA); end
        dado_serial = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        n_checks++; if (db_estado !== REPOUSO) begin n_fail++; $display("FAIL stop_release got %0d want %0d", db_estado, REPOUSO); end
        run_frame(8'h2A, 1'b0, 1'b1, 0, -1, 4, 1'b1, pc, pf);
        n_checks++; if (dados_ascii !== 8'h2A) begin n_fail++; $display("FAIL recover_data got %h want 2a", dados_ascii); end
        n_checks++; if ({pc[1:0], erro_paridade, erro_stop} !== 4'b0100) begin
            n_fail++; $display("FAIL recover_flags got cnt=%0d %b want cnt=1 00", pc, {erro_paridade, erro_stop}); end
    endtask

    task automatic test_glitch();
        int pc;
        pc = 0;
        for (int n = 0; n < 2*M + 4; n++) begin
            dado_serial = (n >= 4);
            @(posedge clock); #1;
            if (pronto) pc++;
        end
        n_checks++; if (pc !== 0) begin n_fail++; $display("FAIL glitch_pronto got %0d want 0", pc); end
        n_checks++; if (db_estado !== REPOUSO) begin n_fail++; $display("FAIL glitch_estado got %0d want %0d", db_estado, REPOUSO); end
        n_checks++; if ({dados_ascii, tem_dado, erro_stop} !== {8'h2A, 2'b10}) begin
            n_fail++; $display("FAIL glitch_hold got %h %b%b want 2a 10", dados_ascii, tem_dado, erro_stop); end
    endtask

    task automatic test_back_to_back();
        int pc, pf;
        test_reset();
        run_frame(8'h31, 1'b0, 1'b1, -1, -1, 0, 1'b1, pc, pf);
        run_frame(8'h32, 1'b0, 1'b1, -1, -1, 4, 1'b1, pc, pf);
        n_checks++; if ({dados_ascii, tem_dado, overrun} !== {8'h32, 2'b11}) begin
            n_fail++; $display("FAIL overrun_set got %h %b%b want 32 11", dados_ascii, tem_dado, overrun); end
        test_reset();
        run_frame(8'h31, 1'b0, 1'b1, -1, -1, 0, 1'b1, pc, pf);
        run_frame(8'h32, 1'b0, 1'b1, PRONTO_STEP + 1, -1, 4, 1'b1, pc, pf);
        n_checks++; if (pf !== PRONTO_STEP) begin n_fail++; $display("FAIL b2b_pronto_time got %0d want %0d", pf, PRONTO_STEP); end
        n_checks++; if ({dados_ascii, tem_dado, overrun} !== {8'h32, 2'b10}) begin
            n_fail++; $display("FAIL limpa_in_final got %h %b%b want 32 10", dados_ascii, tem_dado, overrun); end
    endtask

    task automatic test_reset_mid_frame();
        int pc, pf;
        run_frame(8'h7E, 1'b1, 1'b1, -1, 50, 0, 1'b1, pc, pf);
        n_checks++; if (pc !== 0) begin n_fail++; $display("FAIL midrst_pronto got %0d want 0", pc); end
        n_checks++; if ({db_estado, dados_ascii, pronto, tem_dado, erro_paridade, erro_stop, overrun} !== 17'd0) begin
            n_fail++; $display("FAIL midrst_outputs got %0d %h %b%b%b%b%b want all 0", db_estado, dados_ascii,
                               pronto, tem_dado, erro_paridade, erro_stop, overrun); end
        pc = 0;
        for (int n = 0; n < 2*M; n++) begin
            @(posedge clock); #1;
            if (pronto) pc++;
        end
        n_checks++; if (pc !== 0) begin n_fail++; $display("FAIL midrst_idle_pronto got %0d want 0", pc); end
        run_frame(8'h7E, 1'b1, 1'b1, -1, -1, 4, 1'b1, pc, pf);
        n_checks++; if ({pc[1:0], dados_ascii, tem_dado, erro_paridade, erro_stop} !== {2'd1, 8'h7E, 3'b100}) begin
            n_fail++; $display("FAIL midrst_recover got cnt=%0d %h %b%b%b want cnt=1 7e 100", pc, dados_ascii,
                               tem_dado, erro_paridade, erro_stop); end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_limpa();
        test_parity_error();
        test_stop_error();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
